// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Purpose : Program-counter sequencer with IDLE/RUN/DONE handshake, jump-target
//           table, registered ALU flags and a saturating run-cycle counter.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fetch_sequencer #(
  parameter int D         = 12,
  parameter int LW        = 5,
  parameter int CW        = 16,
  parameter int DONE_ADDR = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req,
  input  logic          stall,
  input  logic          reljump_en,
  input  logic          absjump_en,
  input  logic          branch_cond,
  input  logic [LW-1:0] lut_idx,
  input  logic          lut_we,
  input  logic [LW-1:0] lut_waddr,
  input  logic [D-1:0]  lut_wdata,
  input  logic          flag_we,
  input  logic          zero_i,
  input  logic          pari_i,
  input  logic          sc_i,
  input  logic          sc_clr,
  output logic [D-1:0]  prog_ctr,
  output logic          run,
  output logic          done,
  output logic          zeroQ,
  output logic          pariQ,
  output logic          scQ,
  output logic [CW-1:0] cycles
);

  localparam int          C_NENT    = 1 << LW;
  localparam logic [D-1:0] C_DONE_PC = D'(DONE_ADDR);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [D-1:0]   pc_q, pc_d;
  logic [CW-1:0]  cycles_q, cycles_d;
  logic           zero_q, zero_d;
  logic           pari_q, pari_d;
  logic           sc_q, sc_d;
  logic [D-1:0]   table_q [C_NENT];
  logic [D-1:0]   table_d [C_NENT];
  logic [D-1:0]   w_target;

  // Reads see the registered table, so a same-cycle write returns the old entry.
  assign w_target = table_q[lut_idx];

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cycles_d = cycles_q;
    zero_d   = zero_q;
    pari_d   = pari_q;
    sc_d     = sc_q;
    table_d  = table_q;
    if (lut_we) begin
      table_d[lut_waddr] = lut_wdata;
    end

    case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d  = S_RUN;
          pc_d     = '0;
          cycles_d = '0;
          zero_d   = 1'b0;
          pari_d   = 1'b0;
          sc_d     = 1'b0;
        end
      end
      S_RUN: begin
        if (cycles_q != {CW{1'b1}}) begin
          cycles_d = cycles_q + CW'(1);
        end
        // The end-of-run check wins over stall so a stalled run still finishes.
        if (pc_q == C_DONE_PC) begin
          state_d = S_DONE;
        end else if (!stall) begin
          if (absjump_en && branch_cond) begin
            pc_d = w_target;
          end else if (reljump_en && branch_cond) begin
            pc_d = pc_q + w_target;
          end else begin
            pc_d = pc_q + D'(1);
          end
          if (flag_we) begin
            zero_d = zero_i;
            pari_d = pari_i;
          end
          if (sc_clr) begin
            sc_d = 1'b0;
          end else if (flag_we) begin
            sc_d = sc_i;
          end
        end
      end
      S_DONE: begin
        if (!req) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_q     <= '0;
      cycles_q <= '0;
      zero_q   <= 1'b0;
      pari_q   <= 1'b0;
      sc_q     <= 1'b0;
      table_q  <= '{default: '0};
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cycles_q <= cycles_d;
      zero_q   <= zero_d;
      pari_q   <= pari_d;
      sc_q     <= sc_d;
      table_q  <= table_d;
    end
  end

  assign prog_ctr = pc_q;
  assign cycles   = cycles_q;
  assign zeroQ    = zero_q;
  assign pariQ    = pari_q;
  assign scQ      = sc_q;
  assign run      = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Purpose : Directed and randomized checks of fetch_sequencer against a
//           behavioural model; a small D=4 instance exercises wrap/saturation.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fetch_sequencer;

  localparam int D = 12, LW = 5, CW = 16, DA = 128;
  localparam int PCMOD = 1 << D;
  localparam int CMAX  = (1 << CW) - 1;

  logic clk, reset;
  logic req, stall, reljump_en, absjump_en, branch_cond, lut_we;
  logic flag_we, zero_i, pari_i, sc_i, sc_clr;
  logic [LW-1:0] lut_idx, lut_waddr;
  logic [D-1:0]  lut_wdata;
  logic [D-1:0]  prog_ctr;
  logic          run, done, zeroQ, pariQ, scQ;
  logic [CW-1:0] cycles;

  // small instance
  logic s_req, s_abs, s_cond, s_we;
  logic [1:0] s_idx, s_waddr;
  logic [3:0] s_wdata, s_pc, s_cycles;
  logic s_run, s_done, s_z, s_p, s_s;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_sequencer #(.D(D), .LW(LW), .CW(CW), .DONE_ADDR(DA)) dut (
    .clk(clk), .reset(reset), .req(req), .stall(stall),
    .reljump_en(reljump_en), .absjump_en(absjump_en), .branch_cond(branch_cond),
    .lut_idx(lut_idx), .lut_we(lut_we), .lut_waddr(lut_waddr), .lut_wdata(lut_wdata),
    .flag_we(flag_we), .zero_i(zero_i), .pari_i(pari_i), .sc_i(sc_i), .sc_clr(sc_clr),
    .prog_ctr(prog_ctr), .run(run), .done(done), .zeroQ(zeroQ), .pariQ(pariQ),
    .scQ(scQ), .cycles(cycles)
  );

  fetch_sequencer #(.D(4), .LW(2), .CW(4), .DONE_ADDR(14)) dut_small (
    .clk(clk), .reset(reset), .req(s_req), .stall(1'b0),
    .reljump_en(1'b0), .absjump_en(s_abs), .branch_cond(s_cond),
    .lut_idx(s_idx), .lut_we(s_we), .lut_waddr(s_waddr), .lut_wdata(s_wdata),
    .flag_we(1'b0), .zero_i(1'b0), .pari_i(1'b0), .sc_i(1'b0), .sc_clr(1'b0),
    .prog_ctr(s_pc), .run(s_run), .done(s_done), .zeroQ(s_z), .pariQ(s_p),
    .scQ(s_s), .cycles(s_cycles)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural model: mode 0=idle, 1=running, 2=finished
  int m_mode, m_pc, m_cyc, m_z, m_p, m_s;
  int m_tbl [1 << LW];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_cyc = 0; m_z = 0; m_p = 0; m_s = 0;
    foreach (m_tbl[i]) m_tbl[i] = 0;
  endtask

  task automatic model_step();
    int tgt;
    tgt = m_tbl[lut_idx];
    if (m_mode == 0) begin
      if (req) begin
        m_mode = 1; m_pc = 0; m_cyc = 0; m_z = 0; m_p = 0; m_s = 0;
      end
    end else if (m_mode == 1) begin
      m_cyc = (m_cyc + 1 > CMAX) ? CMAX : m_cyc + 1;
      if (m_pc == DA) m_mode = 2;
      else if (!stall) begin
        if (absjump_en && branch_cond)      m_pc = tgt;
        else if (reljump_en && branch_cond) m_pc = (m_pc + tgt) % PCMOD;
        else                                m_pc = (m_pc + 1) % PCMOD;
        if (flag_we) begin m_z = zero_i; m_p = pari_i; end
        if (sc_clr) m_s = 0;
        else if (flag_we) m_s = sc_i;
      end
    end else begin
      if (!req) m_mode = 0;
    end
    if (lut_we) m_tbl[lut_waddr] = lut_wdata;
  endtask

  task automatic compare_all();
    check_eq("pc", prog_ctr, m_pc);
    check_eq("run", run, m_mode == 1);
    check_eq("done", done, m_mode == 2);
    check_eq("cycles", cycles, m_cyc);
    check_eq("zeroQ", zeroQ, m_z);
    check_eq("pariQ", pariQ, m_p);
    check_eq("scQ", scQ, m_s);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic clear_inputs();
    req = 0; stall = 0; reljump_en = 0; absjump_en = 0; branch_cond = 0;
    lut_idx = '0; lut_we = 0; lut_waddr = '0; lut_wdata = '0;
    flag_we = 0; zero_i = 0; pari_i = 0; sc_i = 0; sc_clr = 0;
  endtask

  task automatic write_tbl(input int idx, input int val);
    lut_we = 1; lut_waddr = LW'(idx); lut_wdata = D'(val);
    cyc();
    lut_we = 0;
  endtask

  initial begin
    clear_inputs();
    s_req = 0; s_abs = 0; s_cond = 0; s_we = 0; s_idx = '0; s_waddr = '0; s_wdata = '0;
    reset = 1;
    model_reset();
    #2;
    compare_all();
    check_eq("small_rst_pc", s_pc, 0);
    #13 reset = 0;

    // Small instance: wrap 15->0 and cycle saturation at 15
    s_we = 1; s_waddr = 2'd1; s_wdata = 4'd15;
    cyc();
    s_we = 0; s_req = 1;
    cyc();
    check_eq("small_run", s_run, 1);
    s_abs = 1; s_cond = 1; s_idx = 2'd1;
    cyc();
    check_eq("small_jump15", s_pc, 15);
    s_abs = 0; s_cond = 0;
    cyc();
    check_eq("small_wrap", s_pc, 0);
    check_eq("small_cyc2", s_cycles, 2);
    for (int i = 0; i < 14; i++) cyc();
    check_eq("small_pc14", s_pc, 14);
    check_eq("small_sat", s_cycles, 15);
    cyc();
    check_eq("small_done", s_done, 1);
    check_eq("small_sat_hold", s_cycles, 15);
    s_req = 0;

    // Straight run 0..128
    req = 1;
    cyc();
    check_eq("run_start", run, 1);
    check_eq("pc_start", prog_ctr, 0);
    for (int i = 0; i < 128; i++) cyc();
    check_eq("pc128", prog_ctr, 128);
    cyc();
    check_eq("done_set", done, 1);
    check_eq("cyc129", cycles, 129);

    // DONE persists while req high, then returns to IDLE
    for (int i = 0; i < 10; i++) begin
      cyc();
      check_eq("done_hold", done, 1);
    end
    req = 0;
    cyc();
    check_eq("idle_done", done, 0);
    check_eq("idle_run", run, 0);
    write_tbl(3, 40);
    write_tbl(4, 10);
    write_tbl(5, 20);
    write_tbl(2, 12'hFFE);
    write_tbl(6, 5);
    req = 1;
    cyc();
    check_eq("rerun_pc", prog_ctr, 0);
    check_eq("rerun_cyc", cycles, 0);

    // Jumps
    for (int i = 0; i < 10; i++) cyc();
    absjump_en = 1; reljump_en = 1; branch_cond = 1; lut_idx = 5'd3;
    cyc();
    check_eq("abs_prio", prog_ctr, 40);
    lut_idx = 5'd4;
    cyc();
    branch_cond = 0; lut_idx = 5'd3;
    cyc();
    check_eq("no_cond", prog_ctr, 11);
    reljump_en = 0; branch_cond = 1; lut_idx = 5'd5;
    cyc();
    absjump_en = 0; reljump_en = 1; lut_idx = 5'd2;
    cyc();
    check_eq("rel_neg", prog_ctr, 18);
    reljump_en = 0; absjump_en = 1; lut_idx = 5'd6;
    cyc();
    absjump_en = 0; branch_cond = 0;

    // Stall and flag behaviour
    stall = 1; flag_we = 1; zero_i = 1; pari_i = 1; sc_i = 1;
    for (int i = 0; i < 3; i++) cyc();
    check_eq("stall_pc", prog_ctr, 5);
    check_eq("stall_flag", zeroQ, 0);
    check_eq("stall_cyc", cycles, 19);
    stall = 0; sc_clr = 1;
    cyc();
    check_eq("sc_clr", scQ, 0);
    check_eq("zero_load", zeroQ, 1);
    flag_we = 0; sc_clr = 0; zero_i = 0;
    for (int i = 0; i < 100 && m_pc != 50; i++) cyc();
    check_eq("pc50", prog_ctr, 50);

    // Asynchronous reset mid-run
    #2 reset = 1;
    model_reset();
    #1;
    compare_all();
    check_eq("areset_run", run, 0);
    #1 reset = 0;
    cyc();
    absjump_en = 1; branch_cond = 1; lut_idx = 5'd3;
    cyc();
    check_eq("tbl_cleared", prog_ctr, 0);
    clear_inputs();

    // Randomized phase
    for (int n = 0; n < 15000; n++) begin
      req         = ($urandom % 4) != 0;
      stall       = ($urandom % 5) == 0;
      absjump_en  = ($urandom % 16) == 0;
      reljump_en  = ($urandom % 16) == 0;
      branch_cond = $urandom % 2;
      lut_idx     = LW'($urandom);
      lut_we      = ($urandom % 8) == 0;
      lut_waddr   = LW'($urandom);
      lut_wdata   = (($urandom % 4) == 0) ? D'(PCMOD - $urandom_range(1, 8))
                                          : D'($urandom_range(0, 130));
      flag_we     = $urandom % 2;
      zero_i      = $urandom % 2;
      pari_i      = $urandom % 2;
      sc_i        = $urandom % 2;
      sc_clr      = ($urandom % 6) == 0;
      cyc();
      if (($urandom % 500) == 0) begin
        #2 reset = 1;
        model_reset();
        #1;
        compare_all();
        #1 reset = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 The module SHALL have parameter D, default 12: program counter width.
REQ-002 The module SHALL have parameter LW, default 5: jump-target table index width (2**LW entries).
REQ-003 The module SHALL have parameter CW, default 16: cycle counter width.
REQ-004 The module SHALL have parameter DONE_ADDR, default 128: PC value that ends a run.
REQ-005 Port clk, input, 1: single clock; all state on rising edge.
REQ-006 Port reset, input, 1: asynchronous, active-high reset.
REQ-007 Port req, input, 1: level start request (4-phase handshake with done).
REQ-008 Port stall, input, 1: holds PC and flags for the current cycle.
REQ-009 Port reljump_en, input, 1: relative jump request.
REQ-010 Port absjump_en, input, 1: absolute jump request.
REQ-011 Port branch_cond, input, 1: jump qualifier; a jump is taken only when this is 1.
REQ-012 Port lut_idx, input, LW: target table read index.
REQ-013 Port lut_we, input, 1; lut_waddr, input, LW; lut_wdata, input, D: target table write port.
REQ-014 Port flag_we, input, 1; zero_i, pari_i, sc_i, inputs, 1 each: ALU flags to register.
REQ-015 Port sc_clr, input, 1: clears registered shift/carry flag.
REQ-016 Port prog_ctr, output, D: current program counter.
REQ-017 Port run, output, 1: high in RUN state.
REQ-018 Port done, output, 1: high in DONE state.
REQ-019 Ports zeroQ, pariQ, scQ, outputs, 1 each: registered flags.
REQ-020 Port cycles, output, CW: RUN-cycle count of the current/last run.

Function
REQ-021 FSM SHALL have states IDLE, RUN, DONE; run and done SHALL be registered-state decodes.
REQ-022 IDLE -> RUN when req=1; on that edge prog_ctr SHALL load 0, cycles SHALL load 0, zeroQ/pariQ/scQ SHALL load 0.
REQ-023 In RUN, when prog_ctr==DONE_ADDR, next state SHALL be DONE; prog_ctr and flags SHALL then hold; this check SHALL ignore stall.
REQ-024 DONE -> IDLE when req=0; DONE SHALL persist while req=1 (no retrigger without req low).
REQ-025 req deassertion during RUN SHALL be ignored.
REQ-026 In RUN with stall=0 and prog_ctr!=DONE_ADDR: if absjump_en&branch_cond, next PC = table[lut_idx]; else if reljump_en&branch_cond, next PC = prog_ctr + table[lut_idx] (D-bit two's complement, modulo 2**D); else prog_ctr+1 modulo 2**D.
REQ-027 absolute jump SHALL take priority when both jump enables are set.
REQ-028 In RUN with stall=1, prog_ctr SHALL hold.
REQ-029 PC increment from 2**D-1 SHALL wrap to 0.
REQ-030 Target table SHALL be 2**LW entries of D bits, combinational read; lut_we SHALL write in any state; a same-cycle write and read of one index SHALL return the old value.
REQ-031 cycles SHALL increment every RUN cycle (stalled or not), saturate at 2**CW-1, and hold in IDLE/DONE.
REQ-032 In RUN with stall=0: flag_we=1 SHALL load zeroQ<=zero_i, pariQ<=pari_i; scQ SHALL load 0 if sc_clr=1, else sc_i if flag_we=1, else hold.
REQ-033 Flags SHALL hold outside RUN and when stall=1.
REQ-034 In IDLE, prog_ctr SHALL hold its value.

Reset
REQ-035 reset=1 SHALL immediately force IDLE, prog_ctr=0, cycles=0, zeroQ=pariQ=scQ=0, run=0, done=0, and all table entries to 0, regardless of clock.
REQ-036 reset asserted mid-RUN SHALL abort the run; after release the block SHALL wait in IDLE for req.

Verification
REQ-037 Reset, req=1, no jumps, DONE_ADDR=128 -> run=1 one cycle later, prog_ctr counts 0..128, done=1 on the cycle after prog_ctr==128, cycles=129.
REQ-038 Table[3]=40, prog_ctr=10, absjump_en=1, reljump_en=1, branch_cond=1, lut_idx=3 -> prog_ctr=40 next cycle; same with branch_cond=0 -> 11.
REQ-039 Table[2]=12'hFFE (-2), prog_ctr=20, reljump_en=1, branch_cond=1 -> prog_ctr=18; D=4, prog_ctr=15, no jump -> 0.
REQ-040 stall=1 for 3 cycles at prog_ctr=5 with flag_we=1 -> prog_ctr stays 5, flags unchanged, cycles +3; sc_clr=1 with flag_we=1, sc_i=1, stall=0 -> scQ=0.
REQ-041 DONE with req held high 10 cycles -> done stays 1; req=0 -> IDLE next cycle; req=1 -> new run from prog_ctr=0, cycles=0.
REQ-042 reset pulse asynchronous to clk mid-RUN at prog_ctr=50 -> prog_ctr=0, run=0, table cleared before next clock edge.
